// File: rtl/grid_painter.sv
// Frame-buffer writer for a 16x12 RGB111 grid: debounced buttons move a cursor,
// paint the cell under it, or sweep-clear the whole grid with the switch colour.
module grid_painter #(
  parameter int AW              = 8,
  parameter int DW              = 3,
  parameter int GRID_W          = 16,
  parameter int GRID_H          = 12,
  parameter int DEBOUNCE_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bntr,
  input  logic          bntl,
  input  logic          bntp,
  input  logic          bntc,
  input  logic [DW-1:0] switch,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic [AW-1:0] cursor_addr,
  output logic          busy
);

  localparam int NCELLS = GRID_W * GRID_H;
  localparam int CNTW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CXW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int CYW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(DEBOUNCE_CYCLES);
  localparam logic [CXW-1:0]  CX_MAX    = CXW'(GRID_W - 1);
  localparam logic [CYW-1:0]  CY_MAX    = CYW'(GRID_H - 1);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(NCELLS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PAINT = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  // Button bit order: 0 right, 1 left, 2 paint, 3 clear.
  logic [3:0]      rawBtn;
  logic [3:0]      sync1_q, sync2_q, stable_q, stableDly_q, press_q;
  logic [CNTW-1:0] cnt_q [4];

  assign rawBtn = {bntc, bntp, bntl, bntr};

  // A full count forces the toggle even if the synced level has just reverted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      stableDly_q <= '0;
      press_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= rawBtn;
      sync2_q     <= sync1_q;
      stableDly_q <= stable_q;
      press_q     <= stable_q & ~stableDly_q;
      for (int i = 0; i < 4; i++) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_q[i] <= ~stable_q[i];
          cnt_q[i]    <= '0;
        end else if (sync2_q[i] != stable_q[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  logic [1:0]    state_q, state_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          regwrite_q, regwrite_d;
  logic          busy_q, busy_d;

  // In CLEAR, addr_q doubles as the sweep index.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    addr_d     = addr_q;
    data_d     = data_q;
    regwrite_d = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_q[3]) begin
          state_d    = S_CLEAR;
          data_d     = switch;
          addr_d     = '0;
          regwrite_d = 1'b1;
          busy_d     = 1'b1;
        end else if (press_q[2]) begin
          state_d    = S_PAINT;
          data_d     = switch;
          addr_d     = cursor_q;
          regwrite_d = 1'b1;
        end else if (press_q[0]) begin
          if (cx_q == CX_MAX) begin
            cx_d = '0;
            cy_d = (cy_q == CY_MAX) ? '0 : cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end else if (press_q[1]) begin
          if (cx_q == '0) begin
            cx_d = CX_MAX;
            cy_d = (cy_q == '0) ? CY_MAX : cy_q - 1'b1;
          end else begin
            cx_d = cx_q - 1'b1;
          end
        end
      end
      S_PAINT: state_d = S_IDLE;
      S_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          addr_d     = addr_q + 1'b1;
          regwrite_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cursor_d = AW'(cy_d) * AW'(GRID_W) + AW'(cx_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      cursor_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      cursor_q   <= cursor_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      regwrite_q <= regwrite_d;
      busy_q     <= busy_d;
    end
  end

  assign addr_in     = addr_q;
  assign data_in     = data_q;
  assign regwrite    = regwrite_q;
  assign cursor_addr = cursor_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_grid_painter.sv
// Scoreboard bench for grid_painter with a short debounce: expected frame-buffer
// writes are queued when buttons are driven and popped as writes appear.
module tb_grid_painter;

  localparam int AW     = 8;
  localparam int DW     = 3;
  localparam int GW     = 16;
  localparam int GH     = 12;
  localparam int DB     = 4;
  localparam int NCELLS = GW * GH;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic          bntr = 1'b0;
  logic          bntl = 1'b0;
  logic          bntp = 1'b0;
  logic          bntc = 1'b0;
  logic [DW-1:0] sw   = '0;
  logic [AW-1:0] addrIn;
  logic [DW-1:0] dataIn;
  logic          regWrite;
  logic [AW-1:0] cursorAddr;
  logic          busyOut;

  grid_painter #(
    .AW(AW), .DW(DW), .GRID_W(GW), .GRID_H(GH), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst),
    .bntr(bntr), .bntl(bntl), .bntp(bntp), .bntc(bntc),
    .switch(sw),
    .addr_in(addrIn), .data_in(dataIn), .regwrite(regWrite),
    .cursor_addr(cursorAddr), .busy(busyOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int writeCount = 0;
  int busyCount = 0;
  bit armLatency = 1'b0;
  int paintStart = 0;
  logic [10:0] expQ[$];
  logic [10:0] expEntry;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  always @(posedge clk) cycle++;

  // Scoreboard side: every observed write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (busyOut === 1'b1) busyCount++;
    if (regWrite === 1'b1) begin
      writeCount++;
      if (armLatency) begin
        armLatency = 1'b0;
        checkOutput("paint_latency", cycle - paintStart, 9);
      end
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write_addr", int'(addrIn), -1);
      end else begin
        expEntry = expQ.pop_front();
        checkOutput("wr_addr", int'(addrIn), int'(expEntry[10:3]));
        checkOutput("wr_data", int'(dataIn), int'(expEntry[2:0]));
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] mask, input int hold, input int settle,
                               input bit timeIt);
    @(posedge clk); #1;
    {bntc, bntp, bntl, bntr} = mask;
    if (timeIt) begin
      paintStart = cycle;
      armLatency = 1'b1;
    end
    repeat (hold) @(posedge clk);
    #1;
    {bntc, bntp, bntl, bntr} = 4'b0000;
    repeat (settle) @(posedge clk);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expQ.delete();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wc;
    int bc;
    int waited;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_regwrite", int'(regWrite), 0);
    checkOutput("rst_busy", int'(busyOut), 0);
    checkOutput("rst_cursor", int'(cursorAddr), 0);
    checkOutput("rst_addr", int'(addrIn), 0);
    checkOutput("rst_data", int'(dataIn), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Paint with a held button: one write, fixed latency, nothing on release
    sw = 3'b100;
    wc = writeCount;
    expQ.push_back({8'd0, 3'b100});
    applyStimulus(4'b0100, 10, 20, 1'b1);
    checkOutput("t1_writes", writeCount - wc, 1);
    checkOutput("t1_queue_empty", expQ.size(), 0);

    // Cursor right wrap across a row, then left wrap from origin
    for (int i = 0; i < 16; i++) applyStimulus(4'b0001, 8, 12, 1'b0);
    checkOutput("t2_cursor16", int'(cursorAddr), 16);
    applyStimulus(4'b0001, 8, 12, 1'b0);
    checkOutput("t2_cursor17", int'(cursorAddr), 17);
    doReset();
    checkOutput("t2_cursor_reset", int'(cursorAddr), 0);
    applyStimulus(4'b0010, 8, 12, 1'b0);
    checkOutput("t2_cursor_left_wrap", int'(cursorAddr), 191);

    // Short glitches must be rejected
    doReset();
    wc = writeCount;
    for (int i = 0; i < 5; i++) applyStimulus(4'b0001, 3, 5, 1'b0);
    repeat (10) @(posedge clk);
    checkOutput("t3_cursor", int'(cursorAddr), 0);
    checkOutput("t3_writes", writeCount - wc, 0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 8, 12, 1'b0);
    checkOutput("t3_cursor3", int'(cursorAddr), 3);

    // Clear sweep with a dropped right press and a switch change mid-sweep
    sw = 3'b010;
    for (int i = 0; i < NCELLS; i++) expQ.push_back({8'(i), 3'b010});
    bc = busyCount;
    wc = writeCount;
    applyStimulus(4'b1000, 8, 0, 1'b0);
    waited = 0;
    while (busyOut !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("t4_busy_seen", int'(busyOut), 1);
    sw = 3'b111;
    applyStimulus(4'b0001, 8, 12, 1'b0);
    waited = 0;
    while (busyOut !== 1'b0 && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (5) @(posedge clk);
    checkOutput("t4_busy_cycles", busyCount - bc, NCELLS);
    checkOutput("t4_writes", writeCount - wc, NCELLS);
    checkOutput("t4_queue_empty", expQ.size(), 0);
    checkOutput("t4_cursor", int'(cursorAddr), 3);

    // Coincident paint and right: paint wins, cursor untouched
    for (int i = 0; i < 2; i++) applyStimulus(4'b0001, 8, 12, 1'b0);
    checkOutput("t5_cursor_pre", int'(cursorAddr), 5);
    sw = 3'b011;
    expQ.push_back({8'd5, 3'b011});
    wc = writeCount;
    applyStimulus(4'b0101, 8, 20, 1'b0);
    checkOutput("t5_writes", writeCount - wc, 1);
    checkOutput("t5_queue_empty", expQ.size(), 0);
    checkOutput("t5_cursor", int'(cursorAddr), 5);

    // Reset in the middle of a sweep
    sw = 3'b001;
    for (int i = 0; i < NCELLS; i++) expQ.push_back({8'(i), 3'b001});
    applyStimulus(4'b1000, 8, 0, 1'b0);
    waited = 0;
    while (addrIn !== 8'd50 && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("t6_addr50", int'(addrIn), 50);
    rst = 1'b0;
    @(posedge clk); #1;
    expQ.delete();
    checkOutput("t6_regwrite", int'(regWrite), 0);
    checkOutput("t6_busy", int'(busyOut), 0);
    checkOutput("t6_cursor", int'(cursorAddr), 0);
    checkOutput("t6_addr", int'(addrIn), 0);
    wc = writeCount;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    checkOutput("t6_no_residual", writeCount - wc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_painter.md
Name: grid_painter

Overview:
- Upstream writer for the dual-port frame buffer; drives its write port (addr_in, data_in, regwrite) in the 75 MHz clock domain.
- The buffer holds a 16x12 grid of RGB111 cells; the VGA read side scales each cell to 64x64 screen pixels.
- Lets the user move a cursor across the grid with buttons, paint the cell under the cursor with the switch colour, or flood-clear the whole grid.

Parameters:
- AW, 8, frame-buffer address width.
- DW, 3, pixel width (RGB111).
- GRID_W, 16, grid columns.
- GRID_H, 12, grid rows. GRID_W*GRID_H must be <= 2^AW.
- DEBOUNCE_CYCLES, 750000, consecutive stable cycles required to accept a button level change (10 ms at 75 MHz). Width of the debounce counter is $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk, in, 1, 75 MHz pixel/system clock.
- rst, in, 1, synchronous reset, active-low.
- bntr, in, 1, raw button, cursor right.
- bntl, in, 1, raw button, cursor left.
- bntp, in, 1, raw button, paint cell.
- bntc, in, 1, raw button, clear grid.
- switch, in, 3, colour to write (RGB111).
- addr_in, out, AW, frame-buffer write address.
- data_in, out, DW, frame-buffer write data.
- regwrite, out, 1, write strobe, one write per high cycle.
- cursor_addr, out, AW, current cursor address = cy*GRID_W+cx.
- busy, out, 1, high while a clear sweep is in progress.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Registered outputs all go to 0: addr_in, data_in, regwrite, busy, cursor_addr.
  - Internal state: cx=cy=0, FSM=IDLE, synchronizers/stable levels/debounce counters = 0.
  - Reset mid-sweep aborts it; no further writes.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter increments while the synced level differs from the stable level, and clears when they are equal.
  - On reaching DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - Press = one-cycle pulse on the stable level's 0->1 edge. Release generates nothing.
  - Latency: raw high sampled at edge 0 -> press pulse high at edge DEBOUNCE_CYCLES+3.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Cursor:
  - Right: cx+1; if cx==GRID_W-1 then cx=0, cy+1, and cy wraps GRID_H-1 -> 0.
  - Left: mirror image; from (0,0) goes to (GRID_W-1, GRID_H-1).
  - cursor_addr is registered and updated the cycle after the press pulse.
- FSM states: IDLE, PAINT, CLEAR.
  - IDLE: acts on at most one pulse per cycle, priority clear > paint > right > left. Lower-priority simultaneous pulses are dropped.
    - Clear pulse -> CLEAR; latch colour=switch, sweep index=0.
    - Paint pulse -> PAINT; latch colour=switch, target=cursor_addr.
    - Right/left pulse -> move cursor, stay in IDLE.
  - PAINT: one cycle with regwrite=1, addr_in=target, data_in=latched colour; then IDLE. regwrite rises exactly 1 cycle after the paint pulse.
  - CLEAR:
    - busy=1 and regwrite=1 every cycle, addr_in = 0,1,...,GRID_W*GRID_H-1, data_in = latched colour.
    - After the last address, go to IDLE; busy and regwrite drop the next cycle.
    - Sweep length is exactly GRID_W*GRID_H cycles (192 by default).
  - All press pulses arriving in PAINT or CLEAR are discarded (no queueing). Cursor is unchanged by a clear.
- Outside PAINT/CLEAR: regwrite=0; addr_in/data_in hold their last values.
- Switch changes after the latch cycle do not affect an ongoing write or sweep.
- Arithmetic: cursor_addr and sweep index are computed in AW bits; no value ever exceeds GRID_W*GRID_H-1.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset, switch=3'b100, bntp held 10 cycles -> exactly one regwrite cycle, 8 cycles after bntp first sampled high, with addr_in=0, data_in=3'b100; no write on release.
2. 17 bntr presses -> cursor_addr=17 (cx=1, cy=1). From reset, one bntl press -> cursor_addr=191.
3. bntr high 3 cycles then low, repeated 5 times -> no pulse, cursor_addr stays 0, regwrite never asserted.
4. switch=3'b010, bntc press; bntr press during the sweep -> busy high for exactly 192 cycles, regwrite high for 192 consecutive cycles with addr_in 0..191 and data_in=3'b010; switch flipped mid-sweep has no effect; cursor_addr unchanged afterwards.
5. bntp and bntr driven identically so both pulses coincide, cursor at 5 -> one write to addr 5; cursor_addr stays 5.
6. Clear running, rst=0 asserted when addr_in=50 -> next edge: regwrite=0, busy=0, cursor_addr=0; after rst release, no residual writes.
